// File: rtl/hamming_pkg.sv
// Shared Hamming(71,64) SEC definitions: widths, the position/data-index mapping
// and data extraction, used by both the encoder and the decoder.
package hamming_pkg;

  localparam int DATA_W = 64;
  localparam int PAR_W  = 7;
  localparam int CODE_W = 71;

  function automatic logic is_pow2(input logic [PAR_W-1:0] pos);
    return (pos != 7'd0) && ((pos & (pos - 7'd1)) == 7'd0);
  endfunction

  // Data index of a non-parity position: subtract the parity slots at or below it.
  function automatic logic [5:0] data_idx(input logic [PAR_W-1:0] pos);
    logic [PAR_W-1:0] n_par;
    n_par = 7'd0;
    for (int k = 0; k < PAR_W; k++) begin
      if ((7'd1 << k) <= pos) n_par = n_par + 7'd1;
    end
    return 6'(pos - n_par - 7'd1);
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = {DATA_W{1'b0}};
    for (int p = 1; p <= CODE_W; p++) begin
      if (!is_pow2(7'(p))) d[data_idx(7'(p))] = code[p-1];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational 7-bit syndrome of a 71-bit codeword; the encoder reuses it for
// parity generation by feeding a codeword with zeroed parity slots.
module hamming_syndrome_calc
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_word,
  output logic [PAR_W-1:0]  syndrome
);

  // Syndrome bit k folds every position whose index has bit k set.
  always_comb begin
    syndrome = {PAR_W{1'b0}};
    for (int p = 1; p <= CODE_W; p++) begin
      for (int k = 0; k < PAR_W; k++) begin
        if (((p >> k) & 1) == 1) syndrome[k] = syndrome[k] ^ code_word[p-1];
      end
    end
  end

endmodule

// File: rtl/hamming_decoder_64bit.sv
// Two-stage Hamming(71,64) SEC decoder with valid/ready backpressure and
// saturating corrected/uncorrectable event counters.
module hamming_decoder_64bit
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] encoded_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  output logic [CNT_W-1:0]  corrected_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clear
);

  logic              adv_s;
  logic              hs_s;
  logic [PAR_W-1:0]  syn_s;
  logic              s1_valid_r;
  logic              s1_en_r;
  logic [CODE_W-1:0] s1_code_r;
  logic [PAR_W-1:0]  s1_syn_r;
  logic [CODE_W-1:0] fix_mask_s;
  logic              corr_s;
  logic              unc_s;

  // Whole pipeline moves as one unit, so ready depends only on the output slot.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;
  assign hs_s     = out_valid && out_ready;

  hamming_syndrome_calc u_syn (
    .code_word (encoded_data),
    .syndrome  (syn_s)
  );

  // Stage 1: capture word, its enable and its syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_en_r    <= 1'b0;
      s1_code_r  <= {CODE_W{1'b0}};
      s1_syn_r   <= {PAR_W{1'b0}};
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_en_r    <= enable;
      s1_code_r  <= encoded_data;
      s1_syn_r   <= syn_s;
    end
  end

  // Classify the syndrome and build the single-bit correction mask.
  always_comb begin
    corr_s     = 1'b0;
    unc_s      = 1'b0;
    fix_mask_s = {CODE_W{1'b0}};
    if (!s1_en_r || (s1_syn_r == 7'd0)) begin
      corr_s = 1'b0;
    end else if (s1_syn_r <= 7'(CODE_W)) begin
      corr_s     = 1'b1;
      fix_mask_s = {{(CODE_W-1){1'b0}}, 1'b1} << (s1_syn_r - 7'd1);
    end else begin
      unc_s = 1'b1;
    end
  end

  // Stage 2: corrected extraction into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      data_out          <= {DATA_W{1'b0}};
      syndrome          <= {PAR_W{1'b0}};
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else if (adv_s) begin
      out_valid         <= s1_valid_r;
      data_out          <= extract_data(s1_code_r ^ fix_mask_s);
      syndrome          <= s1_syn_r;
      err_corrected     <= s1_valid_r && corr_s;
      err_uncorrectable <= s1_valid_r && unc_s;
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      corrected_cnt <= {CNT_W{1'b0}};
      uncorr_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (hs_s && err_corrected && (corrected_cnt != {CNT_W{1'b1}}))
        corrected_cnt <= corrected_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (hs_s && err_uncorrectable && (uncorr_cnt != {CNT_W{1'b1}}))
        uncorr_cnt <= uncorr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
